// File: rtl/axis_tx_upsizer_64to256.sv
// axis_tx_upsizer_64to256
// Packs a 64-bit AXI-Stream TX packet stream into 256-bit words for the
// low-latency MAC TX port. Up to LANES input beats are gathered per output
// word. A word is closed early when tlast arrives. Packets handed to the MAC
// are counted in pkt_cnt.
//
// Handshake: on both ports a beat transfers on a rising clk edge where
// tvalid and tready are both high. Once m_axis_tvalid is raised, the output
// word (data, strb, last, user) is held unchanged until it is taken.
// s_axis_tready depends only on the output slot: it is high when the slot is
// empty or is draining this cycle. It never looks at s_axis_tvalid or tlast.

module axis_tx_upsizer_64to256 #(
    parameter int IN_W  = 64,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_W-1:0]           s_axis_tdata,
    input  logic [IN_W/8-1:0]         s_axis_tstrb,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic                      s_axis_tready,
    output logic [IN_W*LANES-1:0]     m_axis_tdata,
    output logic [IN_W*LANES/8-1:0]   m_axis_tstrb,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    input  logic                      m_axis_tready,
    output logic [CNT_W-1:0]          pkt_cnt
);

    localparam int SW     = IN_W / 8;
    localparam int OUT_W  = IN_W * LANES;
    localparam int OUT_SW = SW * LANES;
    localparam int ACC_N  = LANES - 1;
    localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    // Lane index and partial-word accumulator (lanes 0..LANES-2 only; the
    // top lane is always supplied directly by the completing beat)
    logic [IDX_W-1:0]      r_idx;
    logic [IN_W*ACC_N-1:0] r_acc_data;
    logic [SW*ACC_N-1:0]   r_acc_strb;
    logic                  r_acc_user;

    // Registered output slot
    logic [OUT_W-1:0]      r_m_data;
    logic [OUT_SW-1:0]     r_m_strb;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_m_user;
    logic [CNT_W-1:0]      r_pkt_cnt;

    logic                  w_s_ready;
    logic                  w_accept;
    logic                  w_complete;
    logic [OUT_W-1:0]      w_word_data;
    logic [OUT_SW-1:0]     w_word_strb;
    logic                  w_word_user;

    // Held low during reset; otherwise free when the slot is empty or draining
    assign w_s_ready  = rst_n & (~r_m_valid | m_axis_tready);
    assign w_accept   = s_axis_tvalid & w_s_ready;
    assign w_complete = w_accept & ((r_idx == LAST_IDX) | s_axis_tlast);

    // Assemble the word a completing beat would load: stored lanes below idx,
    // the incoming beat at idx, zero data and strobes above idx
    always_comb begin
        w_word_data = '0;
        w_word_strb = '0;
        w_word_user = r_acc_user | s_axis_tuser;
        for (int k = 0; k < ACC_N; k++) begin
            if (IDX_W'(k) < r_idx) begin
                w_word_data[k*IN_W +: IN_W] = r_acc_data[k*IN_W +: IN_W];
                w_word_strb[k*SW +: SW]     = r_acc_strb[k*SW +: SW];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            if (IDX_W'(k) == r_idx) begin
                w_word_data[k*IN_W +: IN_W] = s_axis_tdata;
                w_word_strb[k*SW +: SW]     = s_axis_tstrb;
            end
        end
    end

    // Store non-completing beats into their lane; restart at lane 0 once a word closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_acc_data <= '0;
            r_acc_strb <= '0;
            r_acc_user <= 1'b0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_idx      <= '0;
                r_acc_data <= '0;
                r_acc_strb <= '0;
                r_acc_user <= 1'b0;
            end else begin
                for (int k = 0; k < ACC_N; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        r_acc_data[k*IN_W +: IN_W] <= s_axis_tdata;
                        r_acc_strb[k*SW +: SW]     <= s_axis_tstrb;
                    end
                end
                r_idx      <= r_idx + IDX_W'(1);
                r_acc_user <= r_acc_user | s_axis_tuser;
            end
        end
    end

    // Output slot: load on a completing beat, otherwise hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data  <= '0;
            r_m_strb  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
        end else if (w_complete) begin
            r_m_data  <= w_word_data;
            r_m_strb  <= w_word_strb;
            r_m_valid <= 1'b1;
            r_m_last  <= s_axis_tlast;
            r_m_user  <= w_word_user;
        end else if (m_axis_tready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Count packets whose final word the MAC has taken; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
        end else if (r_m_valid & m_axis_tready & r_m_last) begin
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tstrb  = r_m_strb;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tuser  = r_m_user;
    assign pkt_cnt       = r_pkt_cnt;

endmodule

// File: tb/tb_axis_tx_upsizer_64to256.sv
// tb_axis_tx_upsizer_64to256
// Drives packets of 64-bit beats into the upsizer and checks the 256-bit words.
// Expected words come from a packet-level model that chunks each packet into
// groups of four beats.

module tb_axis_tx_upsizer_64to256;
  localparam int IN_W   = 64;
  localparam int LANES  = 4;
  localparam int CNT_W  = 16;
  localparam int OUT_W  = IN_W * LANES;
  localparam int OUT_SW = OUT_W / 8;
  localparam int EW     = OUT_W + OUT_SW + 2;

  typedef struct packed {
    logic [IN_W-1:0]   d;
    logic [IN_W/8-1:0] s;
    logic              u;
    logic              l;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic [IN_W-1:0]   s_axis_tdata;
  logic [IN_W/8-1:0] s_axis_tstrb;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tuser;
  logic              s_axis_tready;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic [OUT_SW-1:0] m_axis_tstrb;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic              m_axis_tready;
  logic [CNT_W-1:0]  pkt_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_pkt = 0;
  bit rand_ready = 0;
  bit rand_gaps = 0;

  logic [EW-1:0] exp_q[$];
  beat_t         pkt_q[$];

  axis_tx_upsizer_64to256 #(.IN_W(IN_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .pkt_cnt       (pkt_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Random output backpressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard ----------------
  // Compares every taken word against the expected queue and checks that a
  // stalled word stays unchanged.
  initial begin
    logic [EW-1:0] got_w;
    logic [EW-1:0] exp_w;
    logic [EW-1:0] prev_w;
    bit prev_stall;
    prev_stall = 0;
    prev_w = '0;
    forever begin
      @(negedge clk);
      got_w = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (m_axis_tvalid !== 1'b1 || got_w !== prev_w) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b word=%h required valid=1 word=%h",
                     m_axis_tvalid, got_w, prev_w);
          end
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h required no word", got_w);
          end else begin
            exp_w = exp_q.pop_front();
            if (got_w !== exp_w) begin
              errors++;
              $display("FAIL out_word: got %h required %h", got_w, exp_w);
            end
          end
        end
        prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
        prev_w = got_w;
      end
    end
  end

  // ---------------- reference model ----------------
  // Beat i of a packet lands in word i/LANES, lane i%LANES; a word closes
  // after its fourth lane or on the packet's last beat.
  task automatic model_packet();
    logic [OUT_W-1:0]  wd;
    logic [OUT_SW-1:0] ws;
    logic              wu;
    int                lane;
    wd = '0;
    ws = '0;
    wu = 1'b0;
    for (int i = 0; i < pkt_q.size(); i++) begin
      lane = i % LANES;
      wd = wd | (OUT_W'(pkt_q[i].d) << (IN_W * lane));
      ws = ws | (OUT_SW'(pkt_q[i].s) << ((IN_W / 8) * lane));
      wu = wu | pkt_q[i].u;
      if (lane == LANES - 1 || pkt_q[i].l) begin
        exp_q.push_back({pkt_q[i].l, wu, ws, wd});
        wd = '0;
        ws = '0;
        wu = 1'b0;
      end
    end
    if (pkt_q.size() > 0 && pkt_q[pkt_q.size()-1].l) exp_pkt++;
  endtask

  function automatic beat_t mk(input logic [IN_W-1:0] d, input logic [7:0] s,
                               input logic u, input logic l);
    beat_t b;
    b.d = d;
    b.s = s;
    b.u = u;
    b.l = l;
    return b;
  endfunction

  // ---------------- drivers ----------------
  // Called in the posedge+1 phase; returns in the same phase after acceptance.
  task automatic send_beat(input beat_t b);
    bit ok;
    ok = 0;
    s_axis_tdata  = b.d;
    s_axis_tstrb  = b.s;
    s_axis_tuser  = b.u;
    s_axis_tlast  = b.l;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (s_axis_tready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: tready=%0b required 1 within 300 cycles", s_axis_tready);
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic send_packet();
    model_packet();
    for (int i = 0; i < pkt_q.size(); i++) begin
      if (rand_gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_beat(pkt_q[i]);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(negedge clk);
    ok = (exp_q.size() == 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_drain_and_count(input string name);
    bit ok;
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding required 0", name, exp_q.size());
    end
    checks++;
    if (pkt_cnt !== CNT_W'(exp_pkt)) begin
      errors++;
      $display("FAIL %s_pkt_cnt: got %0d required %0d", name, pkt_cnt, CNT_W'(exp_pkt));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tstrb = '0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_s_tready: got %0b required 0", s_axis_tready);
    end
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/last/user=%b required 000",
               {m_axis_tvalid, m_axis_tlast, m_axis_tuser});
    end
    checks++;
    if (m_axis_tdata !== '0 || m_axis_tstrb !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%h strb=%h required 0", m_axis_tdata, m_axis_tstrb);
    end
    checks++;
    if (pkt_cnt !== '0) begin
      errors++;
      $display("FAIL reset_pkt_cnt: got %0d required 0", pkt_cnt);
    end
    rst_n = 1'b1;
    exp_pkt = 0;
    @(posedge clk);
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_s_tready: got %0b required 1", s_axis_tready);
    end
  endtask

  task automatic test_full_word();
    m_axis_tready = 1'b1;
    pkt_q.delete();
    pkt_q.push_back(mk({8{8'h11}}, 8'hFF, 1'b0, 1'b0));
    pkt_q.push_back(mk({8{8'h22}}, 8'hFF, 1'b0, 1'b0));
    pkt_q.push_back(mk({8{8'h33}}, 8'hFF, 1'b0, 1'b0));
    pkt_q.push_back(mk({8{8'h44}}, 8'hFF, 1'b0, 1'b1));
    model_packet();
    for (int i = 0; i < 4; i++) begin
      send_beat(pkt_q[i]);
      if (i == 2) begin
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL full_early_valid: got %0b required 0 after beat 3", m_axis_tvalid);
        end
      end
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 ||
        m_axis_tdata !== {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}} ||
        m_axis_tstrb !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL full_word_latency: valid=%0b last=%0b data=%h strb=%h required 1 1 44..33..22..11.. ffffffff",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tstrb);
    end
    check_drain_and_count("full_word");
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL full_word_cnt_abs: got %0d required 1", pkt_cnt);
    end
  endtask

  task automatic test_partial_word();
    m_axis_tready = 1'b1;
    pkt_q.delete();
    for (int i = 0; i < 6; i++)
      pkt_q.push_back(mk({$urandom, $urandom}, (i == 5) ? 8'h0F : 8'hFF, 1'b0, i == 5));
    send_packet();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tstrb !== 32'h0000_0FFF ||
        m_axis_tdata[255:128] !== 128'h0) begin
      errors++;
      $display("FAIL partial_tail: valid=%0b last=%0b strb=%h hi=%h required 1 1 00000fff 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata[255:128]);
    end
    check_drain_and_count("partial");
  endtask

  task automatic test_backpressure();
    m_axis_tready = 1'b1;
    pkt_q.delete();
    for (int i = 0; i < 8; i++)
      pkt_q.push_back(mk({$urandom, $urandom}, 8'hFF, 1'b0, i == 7));
    fork
      send_packet();
      begin
        repeat (2) @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1) begin
          errors++;
          $display("FAIL stall_ready: s_tready=%0b m_tvalid=%0b required 0 1",
                   s_axis_tready, m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
      end
    join
    check_drain_and_count("backpressure");
  endtask

  task automatic test_tuser();
    m_axis_tready = 1'b1;
    pkt_q.delete();
    for (int i = 0; i < 4; i++)
      pkt_q.push_back(mk({$urandom, $urandom}, 8'hFF, i == 1, i == 3));
    send_packet();
    checks++;
    if (m_axis_tuser !== 1'b1) begin
      errors++;
      $display("FAIL tuser_set: got %0b required 1", m_axis_tuser);
    end
    pkt_q.delete();
    for (int i = 0; i < 4; i++)
      pkt_q.push_back(mk({$urandom, $urandom}, 8'hFF, 1'b0, i == 3));
    send_packet();
    checks++;
    if (m_axis_tuser !== 1'b0) begin
      errors++;
      $display("FAIL tuser_clear: got %0b required 0", m_axis_tuser);
    end
    check_drain_and_count("tuser");
  endtask

  task automatic test_runt();
    m_axis_tready = 1'b1;
    pkt_q.delete();
    pkt_q.push_back(mk({$urandom, $urandom}, 8'h01, 1'b0, 1'b1));
    send_packet();
    checks++;
    if (m_axis_tstrb !== 32'h0000_0001 || m_axis_tlast !== 1'b1) begin
      errors++;
      $display("FAIL runt_one_byte: strb=%h last=%0b required 00000001 1", m_axis_tstrb, m_axis_tlast);
    end
    pkt_q.delete();
    pkt_q.push_back(mk({$urandom, $urandom}, 8'h00, 1'b0, 1'b1));
    send_packet();
    checks++;
    if (m_axis_tstrb !== 32'h0 || m_axis_tlast !== 1'b1 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL runt_zero_strb: strb=%h last=%0b valid=%0b required 0 1 1",
               m_axis_tstrb, m_axis_tlast, m_axis_tvalid);
    end
    check_drain_and_count("runt");
  endtask

  task automatic test_back_to_back();
    int c0;
    m_axis_tready = 1'b1;
    pkt_q.delete();
    for (int i = 0; i < 8; i++)
      pkt_q.push_back(mk({$urandom, $urandom}, 8'hFF, 1'b0, i == 7));
    c0 = cyc;
    send_packet();
    checks++;
    if (cyc - c0 !== 8) begin
      errors++;
      $display("FAIL throughput: got %0d cycles for 8 beats required 8", cyc - c0);
    end
    check_drain_and_count("back_to_back");
  endtask

  task automatic test_reset_mid_packet();
    m_axis_tready = 1'b1;
    pkt_q.delete();
    for (int i = 0; i < 6; i++)
      pkt_q.push_back(mk({$urandom | 32'h1, $urandom}, 8'hFF, 1'b1, 1'b0));
    send_packet();
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tstrb !== '0 ||
        m_axis_tuser !== 1'b0 || pkt_cnt !== '0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b data=%h strb=%h user=%0b cnt=%0d s_tready=%0b required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tuser, pkt_cnt, s_axis_tready);
    end
    exp_pkt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt_q.delete();
    for (int i = 0; i < 4; i++)
      pkt_q.push_back(mk({$urandom, $urandom}, 8'hFF, 1'b0, i == 3));
    send_packet();
    check_drain_and_count("reset_mid");
  endtask

  task automatic test_random();
    int len;
    int n;
    rand_gaps = 1;
    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 12);
      pkt_q.delete();
      for (int i = 0; i < len; i++) begin
        n = $urandom_range(0, 8);
        pkt_q.push_back(mk({$urandom, $urandom},
                           (i == len - 1) ? 8'((9'd1 << n) - 9'd1) : 8'hFF,
                           ($urandom_range(0, 7) == 0), i == len - 1));
      end
      send_packet();
    end
    rand_ready = 0;
    rand_gaps = 0;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    check_drain_and_count("random");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    test_reset();
    test_full_word();
    test_partial_word();
    test_backpressure();
    test_tuser();
    test_runt();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
